// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select encoding, mul/div occupancy states, zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_muldiv_timer.sv
// Occupancy FSM for multi-cycle mul/div instructions sitting in E.
// Ports: clk, rst_n, start (mul/div entering E), stall (hold pipe), busy (state BUSY).
module hazard_muldiv_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic stall,
    output logic busy
);

    localparam int unsigned CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MULDIV_LAT - 2);
    localparam logic [CW-1:0] ONE = CW'(1);

    localparam logic [0:0] ST_IDLE = HZ_IDLE;
    localparam logic [0:0] ST_BUSY = HZ_BUSY;

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          entry;

    // mul/div arriving in E is only accepted from IDLE; in BUSY the
    // same instruction is being held, so start is ignored.
    assign entry = start && (state_q == ST_IDLE);
    assign busy  = (state_q == ST_BUSY);
    assign stall = entry || busy;

    // cnt holds the BUSY cycles still owed, counting the current one;
    // the cycle that takes it to zero is the last stalled cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (entry) begin
                    cnt_d = LOAD;
                    if (LOAD != '0) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use, branch flush, mul/div stall, E forwarding.
// In: D/E source regs, E/M/W dest regs, writeback/load/branch/muldiv flags. Out: stall/flush/fwd/busy.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              load_e,
    input  logic              pc_src_e,
    input  logic              muldiv_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              busy
);

    localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic     m_ok;
    logic     w_ok;
    logic     lu;
    logic     lu_eff;
    logic     md_start;
    logic     md_stall;
    logic     md_busy;

    assign m_ok = regwrite_m && (rd_m != RZ);
    assign w_ok = regwrite_w && (rd_w != RZ);

    // M is the younger producer, so it wins over W.
    always_comb begin
        fwd_a = FWD_RF;
        if (m_ok && (rd_m == rs1_e)) begin
            fwd_a = FWD_MEM;
        end else if (w_ok && (rd_w == rs1_e)) begin
            fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (m_ok && (rd_m == rs2_e)) begin
            fwd_b = FWD_MEM;
        end else if (w_ok && (rd_w == rs2_e)) begin
            fwd_b = FWD_WB;
        end
    end

    assign lu = load_e && (rd_e != RZ)
             && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A taken branch squashes the dependent instr anyway, and a
    // mul/div occupying E masks lu until it releases.
    assign lu_eff   = lu && !md_stall && !pc_src_e;
    assign md_start = muldiv_e && !pc_src_e;

    hazard_muldiv_timer #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(md_start),
        .stall(md_stall),
        .busy (md_busy)
    );

    // Outputs are forced low for the whole reset interval.
    assign stall_f = rst_n && (md_stall || lu_eff);
    assign stall_d = rst_n && (md_stall || lu_eff);
    assign stall_e = rst_n && md_stall;
    assign flush_m = rst_n && md_stall;
    assign flush_d = rst_n && pc_src_e;
    assign flush_e = rst_n && (pc_src_e || lu_eff);
    assign busy    = rst_n && md_busy;
    assign fwd_a_e = rst_n ? fwd_a : FWD_RF;
    assign fwd_b_e = rst_n ? fwd_b : FWD_RF;

    a_md_br: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(muldiv_e && pc_src_e)
    ) else $warning("hazard_ctrl: muldiv_e with pc_src_e, branch taken");

    a_br_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(md_busy && pc_src_e)
    ) else $warning("hazard_ctrl: pc_src_e while mul/div holds E");

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MULDIV_LAT=4, REG_AW=5).
// Expected output vectors are queued at drive time and compared at the next negedge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e;
    logic [4:0] rd_e, rd_m, rd_w;
    logic       regwrite_m, regwrite_w;
    logic       load_e, pc_src_e, muldiv_e;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    hazard_ctrl #(
        .MULDIV_LAT(4),
        .REG_AW    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_d     (rs1_d),
        .rs2_d     (rs2_d),
        .rs1_e     (rs1_e),
        .rs2_e     (rs2_e),
        .rd_e      (rd_e),
        .rd_m      (rd_m),
        .rd_w      (rd_w),
        .regwrite_m(regwrite_m),
        .regwrite_w(regwrite_w),
        .load_e    (load_e),
        .pc_src_e  (pc_src_e),
        .muldiv_e  (muldiv_e),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .stall_e   (stall_e),
        .flush_d   (flush_d),
        .flush_e   (flush_e),
        .flush_m   (flush_m),
        .fwd_a_e   (fwd_a_e),
        .fwd_b_e   (fwd_b_e),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after %0t", $time);
        $fatal(1);
    end

    // {stall_f,stall_d,stall_e,flush_d,flush_e,flush_m,busy,fwd_a,fwd_b}
    function automatic logic [10:0] ev(
        input logic sf, sd, se, fd, fe, fm, b,
        input logic [1:0] fa, fb
    );
        return {sf, sd, se, fd, fe, fm, b, fa, fb};
    endfunction

    function automatic logic [10:0] obs();
        return {stall_f, stall_d, stall_e, flush_d, flush_e,
                flush_m, busy, fwd_a_e, fwd_b_e};
    endfunction

    function automatic logic [1:0] fwd_model(
        input logic [4:0] rs,
        input logic wm, input logic [4:0] dm,
        input logic ww, input logic [4:0] dw
    );
        if (wm && dm != 5'd0 && dm == rs) return 2'b10;
        if (ww && dw != 5'd0 && dw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        regwrite_m = 0; regwrite_w = 0;
        load_e = 0; pc_src_e = 0; muldiv_e = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] Z   = 11'b0;
    localparam logic [10:0] MD1 = 11'b1110010_0000;
    localparam logic [10:0] MDB = 11'b1110011_0000;
    localparam logic [10:0] LU  = 11'b1100100_0000;
    localparam logic [10:0] BR  = 11'b0001100_0000;

    task automatic test_reset();
        logic [10:0] got, want;
        rst_n = 0;
        clear_inputs();
        pc_src_e = 1; muldiv_e = 1;
        load_e = 1; rd_e = 7; rs2_d = 7;
        regwrite_m = 1; rd_m = 5; rs1_e = 5;
        exp_q.push_back(Z);
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset: got %b want %b", got, want);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1;
        exp_q.push_back(Z);
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", got, want);
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        logic [10:0] got, want;
        logic [4:0]  tm  [4] = '{5, 5, 0, 3};
        logic [4:0]  tw  [4] = '{5, 5, 0, 9};
        logic        twm [4] = '{1, 0, 1, 1};
        logic [4:0]  ta  [4] = '{5, 5, 0, 3};
        logic [4:0]  tb  [4] = '{5, 5, 0, 9};
        logic [1:0]  efa [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
        logic [1:0]  efb [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            rd_m = tm[i]; rd_w = tw[i];
            regwrite_m = twm[i]; regwrite_w = 1;
            rs1_e = ta[i]; rs2_e = tb[i];
            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, efa[i], efb[i]));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fwd_dir[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        for (int i = 0; i < 24; i++) begin
            rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3));
            rs2_e = 5'($urandom_range(0, 3));
            regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1));
            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0,
                fwd_model(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w),
                fwd_model(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w)));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fwd_rand[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [10:0] got, want;
        logic        tl [5] = '{1, 0, 1, 1, 1};
        logic [4:0]  te [5] = '{7, 7, 0, 12, 12};
        logic [4:0]  t1 [5] = '{0, 0, 0, 12, 4};
        logic [4:0]  t2 [5] = '{7, 7, 0, 3, 3};
        logic [10:0] ex [5] = '{LU, Z, Z, LU, Z};
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            load_e = tl[i]; rd_e = te[i];
            rs1_d = t1[i]; rs2_d = t2[i];
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_branch_lu();
        logic [10:0] got, want;
        logic        tl [3] = '{1, 0, 0};
        logic        tp [3] = '{1, 1, 0};
        logic [10:0] ex [3] = '{BR, BR, Z};
        clear_inputs();
        rd_e = 7; rs2_d = 7;
        for (int i = 0; i < 3; i++) begin
            load_e = tl[i]; pc_src_e = tp[i];
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch_lu[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_muldiv();
        logic [10:0] got, want;
        logic        ma [5] = '{1, 0, 0, 0, 0};
        logic        la [5] = '{0, 1, 1, 1, 0};
        logic [10:0] ea [5] = '{MD1, MDB, MDB, LU, Z};
        logic        mb [5] = '{1, 1, 1, 0, 0};
        logic [10:0] eb [5] = '{MD1, MDB, MDB, Z, Z};
        clear_inputs();
        rd_e = 7; rs1_d = 7;
        for (int i = 0; i < 5; i++) begin
            muldiv_e = ma[i]; load_e = la[i];
            exp_q.push_back(ea[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL muldiv_lu[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            muldiv_e = mb[i];
            exp_q.push_back(eb[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL muldiv_hold[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        logic [10:0] got, want;
        logic        tm [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        logic        tr [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
        logic [10:0] ex [8] = '{MD1, Z, Z, Z, MD1, MDB, MDB, Z};
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            muldiv_e = tm[i]; rst_n = tr[i];
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rst_busy[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_illegal();
        logic [10:0] got, want;
        logic        tm [3] = '{1, 0, 0};
        logic        tp [3] = '{1, 0, 0};
        logic [10:0] ex [3] = '{BR, Z, Z};
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            muldiv_e = tm[i]; pc_src_e = tp[i];
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL illegal[%0d]: got %b want %b", i, got, want);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_lu();
        test_muldiv();
        test_reset_mid_busy();
        test_illegal();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
